// File: rtl/sm_switch_debounce_pkg.sv
// Shared clock/debounce settings for the schoolMIPS switch conditioning stage.
// The helper lets users validate a DEBOUNCE/CNT_W pairing before elaboration.
package sm_switch_debounce_pkg;

    localparam int unsigned SM_CLK_HZ        = 50000000;
    localparam int unsigned SM_DEBOUNCE_20MS = 1000000;
    localparam int unsigned SM_DEBOUNCE_SIM  = 4;

    // A count of DEBOUNCE mismatches must be reachable without the counter wrapping.
    function automatic bit debounce_cfg_ok(input int unsigned debounce, input int unsigned cnt_w);
        return (debounce >= 1) && (longint'(debounce) <= (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/sm_switch_debounce_if.sv
// Switch bundle between the raw board switches, the debouncer and its consumers.
// The slave modport is the debouncer side; master drives sw_in and observes the results.
interface sm_switch_debounce_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    modport master (
        output sw_in,
        input  sw_out, sw_rise, sw_fall, sw_changed
    );

    modport slave (
        input  sw_in,
        output sw_out, sw_rise, sw_fall, sw_changed
    );
endinterface

// File: rtl/sm_switch_debounce_bit.sv
// One switch: 2-FF synchroniser, saturating stability counter and registered edge pulses.
// flip is the combinational "sw_out updates at this edge" strobe used for sw_changed.
module sm_debounce_bit
    import sm_switch_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE = SM_DEBOUNCE_20MS,
    parameter int unsigned CNT_W    = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic sw_out,
    output logic rise,
    output logic fall,
    output logic flip
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    assign mismatch = (s2 != sw_out);
    assign flip     = rst_n && mismatch && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            sw_out <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            s1   <= sw_in;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (!mismatch) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                sw_out <= s2;
                cnt    <= '0;
                rise   <= s2;
                fall   <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_switch_debounce.sv
// Conditions WIDTH raw board switches into clean levels plus one-cycle rise/fall pulses.
// Bits are independent; the top only merges the per-bit update strobes into sw_changed.
module sm_switch_debounce
    import sm_switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEBOUNCE = SM_DEBOUNCE_20MS,
    parameter int unsigned CNT_W    = 20
) (
    input  logic                 clkIn,
    input  logic                 rst_n,
    sm_switch_debounce_if.slave  bus
);
    logic [WIDTH-1:0] flip;

    if (!debounce_cfg_ok(DEBOUNCE, CNT_W)) begin : g_bad_cfg
        $error("sm_switch_debounce: DEBOUNCE must be >= 1 and <= 2**CNT_W");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sm_debounce_bit #(
            .DEBOUNCE (DEBOUNCE),
            .CNT_W    (CNT_W)
        ) u_bit (
            .clk    (clkIn),
            .rst_n  (rst_n),
            .sw_in  (bus.sw_in[i]),
            .sw_out (bus.sw_out[i]),
            .rise   (bus.sw_rise[i]),
            .fall   (bus.sw_fall[i]),
            .flip   (flip[i])
        );
    end

    // Registered from the same-edge strobes so it lines up with the per-bit pulses.
    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            bus.sw_changed <= 1'b0;
        end else begin
            bus.sw_changed <= |flip;
        end
    end

endmodule

// File: tb/tb_sm_switch_debounce.sv
// Randomised plus directed bench for sm_switch_debounce (WIDTH=8, DEBOUNCE=4).
// Driver pushes model expectations per edge; a separate monitor pops and compares.
module tb_sm_switch_debounce;
    import sm_switch_debounce_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned D = SM_DEBOUNCE_SIM;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sm_switch_debounce_if #(.WIDTH(W)) bus ();

    sm_switch_debounce #(
        .WIDTH    (W),
        .DEBOUNCE (D),
        .CNT_W    (3)
    ) dut (
        .clkIn (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t         expq[$];
    logic [W-1:0] hist[$];     // value captured by the first sync stage at each edge
    bit           rfl[$];      // edge happened under reset
    logic [W-1:0] mout = '0;
    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] cur;

    // Synchronised level of bit b as seen by the stability logic at edge ed.
    function automatic logic synced(input int ed, input int b);
        if (ed < 2 || rfl[ed-1]) return 1'b0;
        return hist[ed-2][b];
    endfunction

    // Output flips at edge e when the last D non-reset edges all saw the opposite level.
    function automatic bit stable_opposite(input int e, input int b, input logic level);
        for (int i = 0; i < int'(D); i++) begin
            int ed = e - i;
            if (ed < 1 || rfl[ed]) return 1'b0;
            if (synced(ed, b) == level) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input logic rn, input logic [W-1:0] v);
        exp_t         x;
        logic [W-1:0] flip;
        int           e;
        @(negedge clk);
        rst_n     = rn;
        bus.sw_in = v;
        hist.push_back(rn ? v : '0);
        rfl.push_back(!rn);
        e = hist.size() - 1;
        flip = '0;
        if (!rn) begin
            mout = '0;
        end else begin
            for (int b = 0; b < int'(W); b++)
                flip[b] = stable_opposite(e, b, mout[b]);
        end
        x.rise = flip & ~mout;
        x.fall = flip & mout;
        mout   = mout ^ flip;
        x.out  = mout;
        x.chg  = |flip;
        expq.push_back(x);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b1, cur);
    endtask

    // Monitor: every edge the DUT presents a full output set; compare against the queue head.
    initial begin
        exp_t x;
        int   cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                vectors++;
                if (bus.sw_out !== x.out || bus.sw_rise !== x.rise ||
                    bus.sw_fall !== x.fall || bus.sw_changed !== x.chg) begin
                    miscompares++;
                    $display("FAIL edge %0d: out/rise/fall/chg got %h/%h/%h/%b required %h/%h/%h/%b",
                             cyc, bus.sw_out, bus.sw_rise, bus.sw_fall, bus.sw_changed,
                             x.out, x.rise, x.fall, x.chg);
                end
                cyc++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.sw_in = 8'hFF;
        // Reset with switches high, then release: expect a full-width rise.
        cur = 8'hFF;
        step(1'b0, cur); step(1'b0, cur); step(1'b0, cur);
        hold(10);
        // Clean fall on bit 0 from 8'h01.
        cur = 8'h01; hold(10);
        cur = 8'h00; hold(10);
        // Bounce train on bit 3, then settle low.
        for (int i = 0; i < 2; i++) begin
            cur[3] = 1'b1; hold(2);
            cur[3] = 1'b0; hold(2);
        end
        hold(10);
        // Late bounce on bit 3.
        cur[3] = 1'b1; hold(3);
        cur[3] = 1'b0; hold(1);
        cur[3] = 1'b1; hold(10);
        // Simultaneous: bits 2,6 rise while bit 1 falls.
        cur = 8'h0A; hold(10);
        cur = 8'h4C; hold(10);
        // Reset mid-count on bit 5.
        cur = 8'h6C; hold(4);
        step(1'b0, cur);
        hold(10);
        // Random switching with occasional resets.
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 2) begin
                step(1'b0, cur);
            end else begin
                if (r < 30) cur[$urandom_range(0, W-1)] ^= 1'b1;
                step(1'b1, cur);
            end
        end
        hold(12);
        repeat (2) @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
